vc_demux13_buf: RTL and testbench
=================================

VC_DEMUX13_BUF -- requirements
Module: vc_demux13_buf

Interface
REQ-001 The module SHALL have parameter p_nbits, default 32, giving the message payload width.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_val  input  1  input message valid.
REQ-005 in_rdy  output  1  input message accepted when in_val and in_rdy both high at a rising edge.
REQ-006 in_msg  input  p_nbits  input payload; labelled with in_domain.
REQ-007 in_domain  input  1  security domain of in_msg (0 = low/public, 1 = high/secure); label itself public.
REQ-008 sel  input  2  destination port, 0..2 valid, 3 invalid; public.
REQ-009 outN_val  output  1  (N = 0,1,2) port N holds a message.
REQ-010 outN_rdy  input  1  port N consumer ready; transfer when outN_val and outN_rdy both high at a rising edge.
REQ-011 outN_msg  output  p_nbits  port N payload; labelled with outN_domain.
REQ-012 outN_domain  output  1  domain of outN_msg; public.
REQ-013 err_drop  output  1  one-cycle pulse: a message with sel = 3 was discarded.
REQ-014 drop_count  output  8  saturating count of discarded messages.

Function
REQ-015 Each output port SHALL own a one-entry buffer (full flag, msg, domain); ports operate independently.
REQ-016 outN_val SHALL equal buffer N full flag; outN_msg/outN_domain SHALL be driven directly from buffer registers (no combinational path from in_msg).
REQ-017 Latency: a message accepted at edge k SHALL appear on outN_val at edge k (visible cycle k+1); minimum one cycle, no bypass.
REQ-018 in_rdy SHALL be combinational: for sel = N in 0..2, in_rdy = (~fullN) | outN_rdy; for sel = 3, in_rdy = 1.
REQ-019 in_rdy SHALL depend only on sel, full flags and outN_rdy, never on in_msg or in_domain.
REQ-020 Accept with sel = N: buffer N loads in_msg and in_domain, full flag set to 1.
REQ-021 Simultaneous drain and load on the same port (full, outN_rdy = 1, accept to N): buffer reloads with new message, full stays 1, no bubble.
REQ-022 Drain without load: full flag clears at that edge.
REQ-023 Accept on port N SHALL not alter buffers of other ports; drains on other ports in the same cycle proceed normally.
REQ-024 When buffer N is empty, outN_msg SHALL be all zeros and outN_domain SHALL be 0; stale secure data SHALL never remain visible on an empty port.
REQ-025 On drain without load, buffer msg and domain registers SHALL be cleared to zero at the same edge.
REQ-026 Accept with sel = 3: message discarded, no buffer changes, err_drop = 1 in the following cycle only, drop_count increments by 1.
REQ-027 drop_count SHALL saturate at 255 and SHALL not wrap.
REQ-028 Holding in_val high with in_rdy low SHALL not change any state; the producer must hold in_msg, in_domain, sel stable.
REQ-029 in_val low: no buffer load, err_drop = 0 next cycle.

Reset
REQ-030 While reset is low, all full flags, msg and domain registers, err_drop and drop_count SHALL be 0, asynchronously, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all buffered messages without a handshake; no outN_val pulse after release.
REQ-032 First accept SHALL be possible at the first rising edge after reset goes high.

Verification
REQ-033 Reset, then in_val=1, sel=1, in_msg=0xDEADBEEF, in_domain=1, out1_rdy=0 -> next cycle out1_val=1, out1_msg=0xDEADBEEF, out1_domain=1; out0/out2 val=0, msg=0, domain=0.
REQ-034 Port 1 full, out1_rdy=1, new accept sel=1 msg=0x12345678 domain=0 -> in_rdy=1, out1_val stays 1, out1_msg=0x12345678, out1_domain=0 next cycle.
REQ-035 Port 2 full, out2_rdy=0, in_val=1 sel=2 -> in_rdy=0 and state holds for 5 cycles; switching sel to 0 -> in_rdy=1, accept into port 0 while port 2 unchanged.
REQ-036 Port 0 full with domain=1, out0_rdy=1, no new input -> next cycle out0_val=0, out0_msg=0, out0_domain=0.
REQ-037 260 accepts with sel=3 -> err_drop pulses each following cycle, no outN_val, drop_count reads 255 at end.
REQ-038 All three ports full, reset pulled low between edges -> all outN_val, msg, domain, drop_count read 0 immediately; after release, outputs remain 0 until new accept.

Source files
------------

// File: rtl/vc_demux13_buf_if.sv
// ---------------------------------------------------------------------------
// vc_demux13_buf_if
//
// Purpose: bundles the producer-side and consumer-side handshake signals of
// the one-to-three buffered demultiplexer. Each payload travels with a
// one-bit security-domain label.
//
// Signals:
//   in_val, in_rdy, in_msg, in_domain, sel   producer handshake and route
//   outN_val, outN_rdy, outN_msg,
//   outN_domain (N = 0,1,2)                  per-port consumer handshake
//   err_drop, drop_count                     discard reporting
//
// Modports:
//   slave  - the demux itself (receives messages, drives the ports)
//   master - the environment (producer and the three consumers)
// ---------------------------------------------------------------------------
interface vc_demux13_buf_if #(
    parameter int p_nbits = 32
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in_msg;
    logic               in_domain;
    logic [1:0]         sel;

    logic               out0_val;
    logic               out0_rdy;
    logic [p_nbits-1:0] out0_msg;
    logic               out0_domain;

    logic               out1_val;
    logic               out1_rdy;
    logic [p_nbits-1:0] out1_msg;
    logic               out1_domain;

    logic               out2_val;
    logic               out2_rdy;
    logic [p_nbits-1:0] out2_msg;
    logic               out2_domain;

    logic               err_drop;
    logic [7:0]         drop_count;

    modport slave (
        input  in_val, in_msg, in_domain, sel,
        input  out0_rdy, out1_rdy, out2_rdy,
        output in_rdy,
        output out0_val, out0_msg, out0_domain,
        output out1_val, out1_msg, out1_domain,
        output out2_val, out2_msg, out2_domain,
        output err_drop, drop_count
    );

    modport master (
        output in_val, in_msg, in_domain, sel,
        output out0_rdy, out1_rdy, out2_rdy,
        input  in_rdy,
        input  out0_val, out0_msg, out0_domain,
        input  out1_val, out1_msg, out1_domain,
        input  out2_val, out2_msg, out2_domain,
        input  err_drop, drop_count
    );
endinterface

// File: rtl/vc_demux13_buf.sv
// ---------------------------------------------------------------------------
// vc_demux13_buf
//
// Purpose: routes one incoming valid/ready message to one of three output
// ports, each backed by a single-entry buffer. sel = 3 discards the message
// and reports it through err_drop / drop_count. Buffers are zeroed whenever
// they are empty so secure payloads never linger on an idle port.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - vc_demux13_buf_if.slave (producer side, three consumer ports,
//            discard reporting)
// ---------------------------------------------------------------------------
module vc_demux13_buf #(
    parameter int p_nbits = 32
) (
    input  logic            clk,
    input  logic            reset,
    vc_demux13_buf_if.slave bus
);

    // Per-port buffer state, index N = output port N.
    logic [2:0]         full_q, full_d;
    logic [2:0]         dom_q,  dom_d;
    logic [p_nbits-1:0] msg_q [3];
    logic [p_nbits-1:0] msg_d [3];

    logic               err_drop_q, err_drop_d;
    logic [7:0]         drop_count_q, drop_count_d;

    logic [2:0]         out_rdy;
    logic               in_rdy;
    logic               accept;
    logic               drop;

    assign out_rdy = {bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};

    // A port can take a message when its buffer is empty or is being drained
    // this same cycle. Invalid selects are always taken so they can be
    // discarded. Only public signals (sel, full flags, rdy) feed this path.
    always_comb begin
        in_rdy = 1'b1;
        case (bus.sel)
            2'd0:    in_rdy = ~full_q[0] | out_rdy[0];
            2'd1:    in_rdy = ~full_q[1] | out_rdy[1];
            2'd2:    in_rdy = ~full_q[2] | out_rdy[2];
            default: in_rdy = 1'b1;
        endcase
    end

    assign accept = bus.in_val & in_rdy;
    assign drop   = accept & (bus.sel == 2'd3);

    // Buffer next state: a load wins over a drain (reload keeps full set with
    // no bubble); a drain alone empties the buffer and wipes its contents.
    always_comb begin
        full_d = full_q;
        dom_d  = dom_q;
        for (int n = 0; n < 3; n++) begin
            msg_d[n] = msg_q[n];
            if (accept && (bus.sel == 2'(n))) begin
                full_d[n] = 1'b1;
                msg_d[n]  = bus.in_msg;
                dom_d[n]  = bus.in_domain;
            end else if (full_q[n] && out_rdy[n]) begin
                full_d[n] = 1'b0;
                msg_d[n]  = '0;
                dom_d[n]  = 1'b0;
            end
        end
    end

    // Discard reporting: one-cycle pulse and a counter that sticks at 255.
    always_comb begin
        err_drop_d   = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // State registers, all cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q       <= '0;
            dom_q        <= '0;
            err_drop_q   <= 1'b0;
            drop_count_q <= '0;
            for (int n = 0; n < 3; n++) begin
                msg_q[n] <= '0;
            end
        end else begin
            full_q       <= full_d;
            dom_q        <= dom_d;
            err_drop_q   <= err_drop_d;
            drop_count_q <= drop_count_d;
            for (int n = 0; n < 3; n++) begin
                msg_q[n] <= msg_d[n];
            end
        end
    end

    assign bus.in_rdy      = in_rdy;

    assign bus.out0_val    = full_q[0];
    assign bus.out0_msg    = msg_q[0];
    assign bus.out0_domain = dom_q[0];

    assign bus.out1_val    = full_q[1];
    assign bus.out1_msg    = msg_q[1];
    assign bus.out1_domain = dom_q[1];

    assign bus.out2_val    = full_q[2];
    assign bus.out2_msg    = msg_q[2];
    assign bus.out2_domain = dom_q[2];

    assign bus.err_drop    = err_drop_q;
    assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_vc_demux13_buf.sv
// ---------------------------------------------------------------------------
// tb_vc_demux13_buf
//
// Purpose: directed, self-checking bench for vc_demux13_buf. Inputs are
// changed 1 ns after each rising edge and outputs are sampled there too,
// well away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vc_demux13_buf;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;

    vc_demux13_buf_if #(.p_nbits(32)) bus ();

    vc_demux13_buf #(.p_nbits(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the producer side.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [31:0] m, input logic d);
        bus.in_val    = v;
        bus.sel       = s;
        bus.in_msg    = m;
        bus.in_domain = d;
    endtask

    // Check val/msg/domain of one output port.
    task automatic checkPort(input string tag, input int n, input logic v,
                             input logic [31:0] m, input logic d);
        logic        av;
        logic [31:0] am;
        logic        ad;
        case (n)
            0:       begin av = bus.out0_val; am = bus.out0_msg; ad = bus.out0_domain; end
            1:       begin av = bus.out1_val; am = bus.out1_msg; ad = bus.out1_domain; end
            default: begin av = bus.out2_val; am = bus.out2_msg; ad = bus.out2_domain; end
        endcase
        checkOutput($sformatf("%s_out%0d_val", tag, n), 64'(av), 64'(v));
        checkOutput($sformatf("%s_out%0d_msg", tag, n), 64'(am), 64'(m));
        checkOutput($sformatf("%s_out%0d_dom", tag, n), 64'(ad), 64'(d));
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b0;
        bus.out0_rdy = 1'b0;
        bus.out1_rdy = 1'b0;
        bus.out2_rdy = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);

        // Reset state.
        tick();
        tick();
        for (int n = 0; n < 3; n++) checkPort("reset", n, 1'b0, 32'h0, 1'b0);
        checkOutput("reset_err_drop", 64'(bus.err_drop), 64'd0);
        checkOutput("reset_drop_count", 64'(bus.drop_count), 64'd0);
        reset = 1'b1;

        // Secure message to port 1, other ports stay empty and zero.
        applyStimulus(1'b1, 2'd1, 32'hDEADBEEF, 1'b1);
        #1;
        checkOutput("t1_in_rdy", 64'(bus.in_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkPort("t1", 1, 1'b1, 32'hDEADBEEF, 1'b1);
        checkPort("t1", 0, 1'b0, 32'h0, 1'b0);
        checkPort("t1", 2, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_err_drop", 64'(bus.err_drop), 64'd0);

        // Simultaneous drain and reload on port 1.
        bus.out1_rdy = 1'b1;
        applyStimulus(1'b1, 2'd1, 32'h12345678, 1'b0);
        #1;
        checkOutput("t2_in_rdy", 64'(bus.in_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkPort("t2", 1, 1'b1, 32'h12345678, 1'b0);
        tick();
        bus.out1_rdy = 1'b0;
        checkPort("t2_drain", 1, 1'b0, 32'h0, 1'b0);

        // Port 2 stalls the producer; then the route switches to port 0.
        applyStimulus(1'b1, 2'd2, 32'hA5A5A5A5, 1'b1);
        tick();
        applyStimulus(1'b1, 2'd2, 32'h11111111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_stall%0d_in_rdy", i), 64'(bus.in_rdy), 64'd0);
            tick();
            checkPort($sformatf("t3_stall%0d", i), 2, 1'b1, 32'hA5A5A5A5, 1'b1);
        end
        applyStimulus(1'b1, 2'd0, 32'h0BADF00D, 1'b1);
        #1;
        checkOutput("t3_sel0_in_rdy", 64'(bus.in_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkPort("t3", 0, 1'b1, 32'h0BADF00D, 1'b1);
        checkPort("t3", 2, 1'b1, 32'hA5A5A5A5, 1'b1);

        // Drain of secure port 0 wipes its contents.
        bus.out0_rdy = 1'b1;
        tick();
        bus.out0_rdy = 1'b0;
        checkPort("t4", 0, 1'b0, 32'h0, 1'b0);
        checkPort("t4", 2, 1'b1, 32'hA5A5A5A5, 1'b1);

        // Accept into port 1 while port 2 drains in the same cycle.
        bus.out2_rdy = 1'b1;
        applyStimulus(1'b1, 2'd1, 32'hCAFE0001, 1'b1);
        tick();
        bus.out2_rdy = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkPort("t5", 1, 1'b1, 32'hCAFE0001, 1'b1);
        checkPort("t5", 2, 1'b0, 32'h0, 1'b0);

        // 260 discards: pulse every cycle, counter saturates at 255.
        applyStimulus(1'b1, 2'd3, 32'hFFFFFFFF, 1'b1);
        for (int i = 0; i < 260; i++) begin
            checkOutput($sformatf("t6_in_rdy%0d", i), 64'(bus.in_rdy), 64'd1);
            tick();
            checkOutput($sformatf("t6_err_drop%0d", i), 64'(bus.err_drop), 64'd1);
            checkOutput($sformatf("t6_count%0d", i), 64'(bus.drop_count),
                        (i + 1 > 255) ? 64'd255 : 64'(i + 1));
            checkOutput($sformatf("t6_out0_val%0d", i), 64'(bus.out0_val), 64'd0);
            checkOutput($sformatf("t6_out2_val%0d", i), 64'(bus.out2_val), 64'd0);
        end
        applyStimulus(1'b0, 2'd3, 32'h0, 1'b0);
        tick();
        checkOutput("t6_err_drop_end", 64'(bus.err_drop), 64'd0);
        checkOutput("t6_count_end", 64'(bus.drop_count), 64'd255);
        checkPort("t6", 1, 1'b1, 32'hCAFE0001, 1'b1);

        // Fill all three ports, then reset between edges.
        applyStimulus(1'b1, 2'd0, 32'h00000100, 1'b1);
        tick();
        applyStimulus(1'b1, 2'd2, 32'h00000200, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkOutput("t7_full0", 64'(bus.out0_val), 64'd1);
        checkOutput("t7_full2", 64'(bus.out2_val), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) checkPort("t7_async", n, 1'b0, 32'h0, 1'b0);
        checkOutput("t7_async_count", 64'(bus.drop_count), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        for (int n = 0; n < 3; n++) checkPort("t7_post", n, 1'b0, 32'h0, 1'b0);

        // First accept right after reset release.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 2'd0, 32'h00000055, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkPort("t8", 0, 1'b1, 32'h00000055, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
